// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, FSM states and instruction field positions for control_unit (optional JC via CTRL_CARRY_BRANCH_EN)
package ctrl_pkg;
   localparam int OP_MSB = 15;
   localparam int RD_LSB = 8;
   localparam int RA_LSB = 4;
   localparam int RB_LSB = 0;
   localparam int FLD_W  = 4;
   localparam int IMM_W  = 8;
   localparam logic [3:0] OP_LDI  = 4'h8;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_JZ   = 4'hB;
   localparam logic [3:0] OP_JC   = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
   typedef struct packed {
      logic [2:0] alu_opcode;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [3:0] rd;
      logic [7:0] imm;
      logic       is_alu;
      logic       is_ldi;
      logic       is_jmp;
      logic       is_jz;
      logic       is_jc;
      logic       is_halt;
   } dec_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction decoder; JC recognised only when CTRL_CARRY_BRANCH_EN is defined
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [15:0] i_ir,
   output dec_t        o_dec
);
   logic [3:0] w_op;
   assign w_op = i_ir[OP_MSB -: FLD_W];
   // register selects are zeroed for classes that do not use them, so idle outputs stay quiet
   always_comb begin
      o_dec            = '0;
      o_dec.is_alu     = ~w_op[3];
      o_dec.is_ldi     = w_op == OP_LDI;
      o_dec.is_jmp     = w_op == OP_JMP;
      o_dec.is_jz      = w_op == OP_JZ;
      o_dec.is_halt    = w_op == OP_HALT;
`ifdef CTRL_CARRY_BRANCH_EN
      o_dec.is_jc      = w_op == OP_JC;
`endif
      o_dec.imm        = i_ir[IMM_W-1:0];
      o_dec.alu_opcode = o_dec.is_alu ? w_op[2:0] : 3'd0;
      o_dec.ra         = o_dec.is_alu ? i_ir[RA_LSB +: FLD_W] : 4'd0;
      o_dec.rb         = o_dec.is_alu ? i_ir[RB_LSB +: FLD_W] : 4'd0;
      o_dec.rd         = (o_dec.is_alu | o_dec.is_ldi) ? i_ir[RD_LSB +: FLD_W] : 4'd0;
   end
endmodule

// File: rtl/control_unit.sv
// control_unit: 3-cycle fetch/decode/execute sequencer; CTRL_CARRY_BRANCH_EN enables JC (op 1100)
module control_unit
   import ctrl_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [PC_W-1:0] instr_addr,
   input  logic [15:0]     instr_data,
   output logic [3:0]      ra_addr,
   output logic [3:0]      rb_addr,
   output logic [3:0]      write_addr,
   output logic [2:0]      alu_opcode,
   output logic            alu_en,
   output logic            write_en,
   output logic [7:0]      user_write_data,
   input  logic            alu_zero,
   input  logic            alu_carry,
   output logic            busy,
   output logic            halted
);
   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic [15:0]     r_ir;
   logic            r_zf;
   logic            r_cf;
   dec_t            w_dec;
   logic            w_exec;
   logic            w_take;

   ctrl_decode u_decode (.i_ir(r_ir), .o_dec(w_dec));

   assign w_exec          = r_state == S_EXEC;
   assign w_take          = w_dec.is_jmp | (w_dec.is_jz & r_zf) | (w_dec.is_jc & r_cf);
   assign instr_addr      = r_pc;
   assign ra_addr         = w_dec.ra;
   assign rb_addr         = w_dec.rb;
   assign write_addr      = w_dec.rd;
   assign alu_opcode      = w_dec.alu_opcode;
   assign user_write_data = w_dec.is_ldi ? w_dec.imm : 8'd0;
   assign alu_en          = w_exec & w_dec.is_alu;
   assign write_en        = w_exec & (w_dec.is_alu | w_dec.is_ldi);
   assign busy            = r_state inside {S_FETCH, S_DECODE, S_EXEC};
   assign halted          = r_state == S_HALT;

   // sequencer: IR latched leaving DECODE, flags and pc committed leaving EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_ir    <= '0;
         r_zf    <= 1'b0;
         r_cf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_pc    <= '0;
               r_state <= S_FETCH;
            end
            S_FETCH: r_state <= S_DECODE;
            S_DECODE: begin
               r_ir    <= instr_data;
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               if (w_dec.is_alu) begin
                  r_zf <= alu_zero;
                  r_cf <= alu_carry;
               end
               r_pc    <= w_take ? PC_W'(w_dec.imm) : r_pc + PC_W'(1);
               r_state <= w_dec.is_halt ? S_HALT : S_FETCH;
            end
            S_HALT: if (start) begin
               r_pc    <= '0;
               r_zf    <= 1'b0;
               r_cf    <= 1'b0;
               r_state <= S_FETCH;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed programs with a write scoreboard and fetch-address checks for control_unit
module tb_control_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  instr_addr;
   logic [15:0] instr_data;
   logic [3:0]  ra_addr, rb_addr, write_addr;
   logic [2:0]  alu_opcode;
   logic        alu_en, write_en, alu_zero, alu_carry, busy, halted;
   logic [7:0]  user_write_data;
   logic [15:0] mem [256];
   logic [7:0]  regs [16] = '{default: 8'h00};
   logic [8:0]  res;
   logic [7:0]  wdata;
   int          total = 0;
   int          bad = 0;
   int          n_wr = 0;

   typedef struct packed {logic [3:0] a; logic [7:0] d;} wr_t;
   wr_t sb[$];

   always #5 clk = ~clk;

   control_unit #(.PC_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .instr_addr(instr_addr), .instr_data(instr_data),
      .ra_addr(ra_addr), .rb_addr(rb_addr), .write_addr(write_addr), .alu_opcode(alu_opcode),
      .alu_en(alu_en), .write_en(write_en), .user_write_data(user_write_data),
      .alu_zero(alu_zero), .alu_carry(alu_carry), .busy(busy), .halted(halted)
   );

   // datapath model: 0 ADD, 1 SUB (bit 8 = borrow), 2 AND, 3 OR, 4 XOR, others pass A
   function automatic logic [8:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0: return {1'b0, a} + {1'b0, b};
         3'd1: return {1'b0, a} - {1'b0, b};
         3'd2: return {1'b0, a & b};
         3'd3: return {1'b0, a | b};
         3'd4: return {1'b0, a ^ b};
         default: return {1'b0, a};
      endcase
   endfunction

   assign res       = alu(alu_opcode, regs[ra_addr], regs[rb_addr]);
   assign alu_zero  = res[7:0] == 8'h00;
   assign alu_carry = res[8];
   assign wdata     = alu_en ? res[7:0] : user_write_data;

   always @(posedge clk) begin
      instr_data <= mem[instr_addr];
      if (write_en) regs[write_addr] <= wdata;
   end

   task automatic chk(input string n, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", n, act, exp);
      end
   endtask

   // monitor: every write strobe must match the oldest expected write
   always @(negedge clk) if (write_en) begin
      n_wr++;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", write_addr, wdata);
      end else begin
         wr_t e;
         e = sb.pop_front();
         chk("wr", {20'd0, write_addr, wdata}, {20'd0, e.a, e.d});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clr;
      for (int i = 0; i < 256; i++) mem[i] = 16'h9000;
   endtask

   task automatic push(input logic [3:0] a, input logic [7:0] d);
      sb.push_back({a, d});
   endtask

   task automatic pulse;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic chk_zero(input string n);
      chk({n, "_addr"}, instr_addr, 0);
      chk({n, "_ctl"}, {busy, halted, alu_en, write_en}, 0);
      chk({n, "_dp"}, {ra_addr, rb_addr, write_addr, alu_opcode, user_write_data}, 0);
   endtask

   initial begin
      clr();
      tick(2);
      chk_zero("reset");
      rst_n = 1'b1;
      tick(1);
      // LDI r1,1; LDI r0,0; ADD r0,r0,r1; HALT
      mem[0] = 16'h8101; mem[1] = 16'h8000; mem[2] = 16'h0001; mem[3] = 16'hF000;
      push(1, 8'h01); push(0, 8'h00); push(0, 8'h01);
      n_wr = 0;
      pulse();
      chk("t1_first_fetch", {busy, instr_addr}, {1'b1, 8'h00});
      tick(3);
      chk("t1_fetch1", instr_addr, 1);
      tick(8);
      chk("t1_not_yet_halted", halted, 0);
      tick(1);
      chk("t1_halted", {halted, busy}, 2'b10);
      chk("t1_r0", regs[0], 1);
      chk("t1_nwr", n_wr, 3);
      // SUB r2,r2,r2; JZ 0x10 (restart from HALT)
      clr();
      mem[0] = 16'h1222; mem[1] = 16'hB010; mem[16'h10] = 16'hF000;
      push(2, 8'h00);
      pulse();
      chk("t2_restart", {busy, halted, instr_addr}, {2'b10, 8'h00});
      tick(6);
      chk("t2_jz_taken", instr_addr, 8'h10);
      tick(3);
      chk("t2_halted", halted, 1);
      // restart clears zero flag: JZ falls through
      clr();
      mem[0] = 16'hB020; mem[1] = 16'hF000; mem[16'h20] = 16'hF000;
      pulse();
      tick(3);
      chk("t2_zf_cleared", instr_addr, 1);
      tick(3);
      chk("t2_halted2", halted, 1);
      // LDI r3,5; LDI r4,3; SUB r2,r3,r4; JZ 0x10 -> not taken
      clr();
      mem[0] = 16'h8305; mem[1] = 16'h8403; mem[2] = 16'h1234; mem[3] = 16'hB010;
      mem[4] = 16'hF000; mem[16'h10] = 16'hF000;
      push(3, 8'h05); push(4, 8'h03); push(2, 8'h02);
      pulse();
      tick(12);
      chk("t2_jz_not_taken", instr_addr, 4);
      tick(3);
      chk("t2_halted3", halted, 1);
      // LDI r6,FF; LDI r7,1; ADD r8,r6,r7; JC 0x40
      clr();
      mem[0] = 16'h86FF; mem[1] = 16'h8701; mem[2] = 16'h0867; mem[3] = 16'hC040;
      mem[4] = 16'hF000; mem[16'h40] = 16'hF000;
      push(6, 8'hFF); push(7, 8'h01); push(8, 8'h00);
      pulse();
      tick(12);
`ifdef CTRL_CARRY_BRANCH_EN
      chk("t6_jc", instr_addr, 8'h40);
`else
      chk("t6_jc_nop", instr_addr, 8'h04);
`endif
      tick(3);
      chk("t6_halted", halted, 1);
      // start pulsed while busy is ignored
      clr();
      mem[3] = 16'hF000;
      pulse();
      tick(4);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(1);
      chk("t5_busy_start", instr_addr, 2);
      tick(6);
      chk("t5_halted", halted, 1);
      // JMP 0xFF; NOP at 0xFF wraps to 0
      clr();
      mem[0] = 16'hA0FF;
      pulse();
      tick(3);
      chk("t3_jmp", instr_addr, 8'hFF);
      tick(3);
      chk("t3_wrap", instr_addr, 8'h00);
      // reset during EXEC of LDI r5,0x11
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      clr();
      mem[0] = 16'h8511;
      pulse();
      tick(1);
      @(posedge clk);
      #1;
      chk("t4_in_exec", write_en, 1);
      rst_n = 1'b0;
      #1;
      chk_zero("t4_rst");
      tick(2);
      rst_n = 1'b1;
      chk("t4_r5_kept", regs[5], 0);
      tick(3);
      chk("t4_idle", {busy, halted, instr_addr}, 0);
      push(5, 8'h11);
      pulse();
      chk("t4_resume", {busy, instr_addr}, {1'b1, 8'h00});
      tick(3);
      chk("t4_r5_written", regs[5], 8'h11);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter and instruction-address width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  begin execution at address 0 when idle or halted.
REQ-005 SHALL have port instr_addr  output  PC_W  program-memory address.
REQ-006 SHALL have port instr_data  input  16  program-memory word, valid one cycle after instr_addr.
REQ-007 SHALL have ports ra_addr, rb_addr, write_addr  output  4 each  datapath register selects.
REQ-008 SHALL have port alu_opcode  output  3  datapath ALU operation.
REQ-009 SHALL have ports alu_en, write_en  output  1 each  ALU-result select and register write strobe.
REQ-010 SHALL have port user_write_data  output  8  immediate write data.
REQ-011 SHALL have ports alu_zero, alu_carry  input  1 each  datapath flags.
REQ-012 SHALL have ports busy and halted  output  1 each  state indicators.

Function
REQ-013 SHALL decode the instruction word as op[15:12], rd[11:8], ra[7:4], rb[3:0], with imm8 = instr[7:0].
REQ-014 SHALL decode op 0xxx as ALU: alu_opcode=op[2:0], ra_addr=ra, rb_addr=rb, write_addr=rd, alu_en=1.
REQ-015 SHALL decode 1000 as LDI (rd <= imm8, alu_en=0), 1001 as NOP, 1010 as JMP imm8, 1011 as JZ imm8, 1111 as HALT, and every other op as NOP.
REQ-016 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, HALT.
REQ-017 IDLE: start=1 -> pc=0, go to FETCH; start=0 -> stay.
REQ-018 FETCH: drive instr_addr=pc, then go to DECODE.
REQ-019 DECODE: latch instr_data into IR, then go to EXEC.
REQ-020 EXEC: drive the decoded datapath signals for exactly one cycle, update pc, then go to FETCH (or to HALT on HALT).
REQ-021 SHALL assert write_en for exactly the one EXEC cycle of ALU and LDI instructions, and never in any other state.
REQ-022 SHALL hold ra_addr, rb_addr, write_addr, alu_opcode and user_write_data stable from DECODE exit through EXEC.
REQ-023 SHALL register the zero flag from alu_zero and the carry flag from alu_carry at the EXEC edge of ALU instructions only; LDI, NOP and jumps SHALL leave both flags unchanged.
REQ-024 SHALL, for JZ, load pc=imm8 when the zero flag is 1 and pc=pc+1 otherwise; JMP SHALL always load pc=imm8.
REQ-025 SHALL increment pc modulo 2^PC_W, so pc 0xFF wraps to 0x00 with no fault.
REQ-026 SHALL take 3 cycles per instruction, independent of opcode.
REQ-027 SHALL ignore start while busy.
REQ-028 HALT: halted=1; start=1 -> pc=0, both flags cleared, go to FETCH.
REQ-029 SHALL drive busy=1 in FETCH, DECODE and EXEC, and busy=0 in IDLE and HALT.
REQ-030 SHALL drive alu_en=0 and write_en=0 in every state except EXEC.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE, pc=0, IR=0, both flags=0, and every output to 0, including mid-instruction.
REQ-032 Reset asserted during EXEC SHALL suppress write_en in that cycle, so no register write occurs.
REQ-033 SHALL resume at IDLE on reset release and wait for start.

Configuration
REQ-034 Macro CTRL_CARRY_BRANCH_EN defined: op 1100 SHALL be JC imm8 (pc=imm8 when the carry flag is 1, else pc+1).
REQ-035 Macro CTRL_CARRY_BRANCH_EN undefined: op 1100 SHALL behave as NOP, and the carry flag register may be omitted.

Structure
REQ-036 Package ctrl_pkg SHALL hold the op encodings, the FSM state encoding, and the instruction field-position constants.
REQ-037 SHALL instantiate one combinational sub-module ctrl_decode (IR in, datapath controls and instruction-class flags out); the FSM and pc SHALL stay in control_unit.

Verification
REQ-038 The bench SHALL cover: program LDI r1,0x01; LDI r0,0x00; ADD r0,r0,r1; HALT -> r0=0x01, halted=1 after 12 cycles, write_en pulsed 3 times.
REQ-039 The bench SHALL cover: SUB r2,r2,r2 then JZ 0x10 -> next instr_addr=0x10; with r2 nonzero operands -> next instr_addr=pc+1.
REQ-040 The bench SHALL cover: JMP 0xFF, NOP at 0xFF -> after the NOP, instr_addr=0x00 (wrap).
REQ-041 The bench SHALL cover: rst_n dropped during EXEC of LDI r5,0x11 -> r5 unchanged, all outputs 0, state IDLE.
REQ-042 The bench SHALL cover: start pulsed while busy -> no pc change; start while halted -> restart at instr_addr=0x00.
REQ-043 The bench SHALL cover: with CTRL_CARRY_BRANCH_EN, ADD of 0xFF+0x01 then JC 0x40 -> instr_addr=0x40; without the macro -> pc+1.
